dds_phase_mac_pipe: RTL and testbench
=====================================

Name: dds_phase_mac_pipe

Overview:
- Parametrised, fully pipelined phase MAC for the DAC controller's DDS path.
- Computes phase_out = (timestamp − time_offset) × freq + (phase_ofs << (PHASE_W−POFS_W)) + acc_phase, all modulo 2^PHASE_W.
- Adds over the previous fixed-48-bit phase MAC:
  - valid/ready stream handshake with backpressure;
  - registered time-offset load;
  - generic limb-based truncated multiply;
  - optional negative-time diagnostics.
- Sits between the timestamp/RTIO command decoder and the DDS phase-to-amplitude stage.

Parameters:
- PHASE_W, 48, width of freq, acc_phase and phase_out. Must be a multiple of LIMB_W.
- TIME_W, 48, width of timestamp and time_offset. Elapsed time is zero-extended or truncated to PHASE_W.
- POFS_W, 14, width of the phase_ofs word, left-aligned into the top bits of the phase.
- LIMB_W, 16, partial-product limb width. NL = PHASE_W/LIMB_W limbs.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cfg_load  in  1  load cfg_time_offset into the time-offset register
- cfg_time_offset  in  TIME_W  new time offset
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts a sample this cycle
- s_timestamp  in  TIME_W  sample timestamp
- s_freq  in  PHASE_W  frequency tuning word
- s_phase_ofs  in  POFS_W  phase offset word
- s_acc_phase  in  PHASE_W  accumulated phase to add
- m_valid  out  1  output valid
- m_ready  in  1  downstream accepts output
- m_phase  out  PHASE_W  result phase
- m_neg_time  out  1  sample had timestamp < time_offset (only with macro, else 0)
- err_cnt  out  16  saturating count of negative-time samples (only with macro, else 0)

Behaviour:
- Reset: clock and reset are as already decided — one clock, clk; reset is resetn, asynchronous and active-low. On reset assertion:
  - all stage valid bits, m_valid, m_phase, m_neg_time, err_cnt and the time-offset register go to 0;
  - data registers go to 0;
  - in-flight samples are dropped.
- s_ready = 0 while resetn is low.
- Pipeline: 4 stages, latency exactly 4 cycles from an s_valid & s_ready edge to m_valid, with no stalls.
  - S0: elapsed = (s_timestamp − toff) mod 2^TIME_W. Register elapsed, freq, the aligned phase offset, acc_phase and the neg flag (s_timestamp < toff, unsigned).
  - S1: register partial products P(i,j) = elapsed limb i × freq limb j for i+j < NL only; products above PHASE_W are discarded (truncation).
  - S2: register Σ P(i,j) << (LIMB_W·(i+j)) mod 2^PHASE_W, plus aligned phase offset.
  - S3: output register = (S2 sum + acc_phase) mod 2^PHASE_W. m_neg_time is carried along with the sample.
- Aligned phase offset = s_phase_ofs << (PHASE_W−POFS_W). Example: 14'h3FFF → 48'hFFFC_0000_0000.
- Handshake: global stall. adv = ~m_valid | m_ready.
  - All stages shift only when adv = 1; s_ready = adv.
  - Bubbles (valid = 0) propagate and never produce m_valid.
  - m_phase and m_valid are held stable while m_valid & ~m_ready.
  - No sample is lost or duplicated; order is preserved.
- Time offset: toff updates on the clk edge when cfg_load = 1.
  - A sample accepted in the same cycle as cfg_load uses the old toff; samples accepted later use the new one.
  - In-flight samples are unaffected.
- Wrap-around: all arithmetic wraps modulo its width; no saturation. Negative elapsed time wraps (two's complement).
- Simultaneous cfg_load and stall: the load still takes effect; it is independent of adv.

Optional Feature:
- Macro: DDS_PHASE_MAC_NEGTIME_EN.
- Defined:
  - m_neg_time reflects each output sample's flag.
  - err_cnt increments by 1 on every accepted input with the neg flag set, and saturates at 16'hFFFF.
  - cfg_load clears err_cnt. If cfg_load and a counted sample coincide, the result is 1.
- Undefined: m_neg_time and err_cnt are constant 0; no counter logic is present. The ports remain, so the bench is shared.

Test Plan:
- Basic: toff = 100 via cfg_load; then ts = 110, freq = 48'h1_0000_0000, phase_ofs = 0, acc = 0 → m_phase = 48'h000A_0000_0000, m_valid exactly 4 cycles after acceptance.
- Wrap/truncation: toff = 0, ts = 2, freq = 48'hFFFF_FFFF_FFFF, acc = 48'h5 → m_phase = 48'h0000_0000_0003. Phase_ofs only: 14'h3FFF, freq = 0 → 48'hFFFC_0000_0000.
- Backpressure: 6 back-to-back samples ts = 1..6, toff = 0, freq = 1; m_ready low cycles 3–5 → outputs 1..6 in order, none lost, m_phase stable while stalled, s_ready low while stalled with m_valid high.
- Offset timing: cfg_load toff = 50 in the same cycle as accepting ts = 60 (old toff = 0), freq = 1, then ts = 60 again → outputs 60 then 10.
- Negative time (macro on): toff = 10, ts = 5, freq = 1 → m_phase = 48'hFFFF_FFFF_FFFB, m_neg_time = 1, err_cnt = 1. Then cfg_load → err_cnt = 0. Macro off: same m_phase, flag and count 0.
- Reset mid-stream: assert resetn = 0 with 3 samples in flight → m_valid = 0 and m_phase = 0 immediately (asynchronous), toff = 0. After release, no stale outputs appear.

Source files
------------

// File: rtl/dds_phase_mac_pipe.sv
// dds_phase_mac_pipe: 4-stage pipelined DDS phase MAC with a global-stall valid/ready handshake.
// Define DDS_PHASE_MAC_NEGTIME_EN to enable the negative-time flag and saturating error counter.
`timescale 1ns/1ps
module dds_phase_mac_pipe #(
    parameter int PHASE_W = 48,
    parameter int TIME_W  = 48,
    parameter int POFS_W  = 14,
    parameter int LIMB_W  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cfg_load,
    input  logic [TIME_W-1:0]  cfg_time_offset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [TIME_W-1:0]  s_timestamp,
    input  logic [PHASE_W-1:0] s_freq,
    input  logic [POFS_W-1:0]  s_phase_ofs,
    input  logic [PHASE_W-1:0] s_acc_phase,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PHASE_W-1:0] m_phase,
    output logic               m_neg_time,
    output logic [15:0]        err_cnt
);
    localparam int NL = PHASE_W / LIMB_W;

    logic                w_adv;
    logic                w_acc;
    logic [TIME_W-1:0]   w_diff;
    logic [PHASE_W-1:0]  w_el;
    logic [PHASE_W-1:0]  w_po;
    logic [PHASE_W-1:0]  w_sum;
    logic [TIME_W-1:0]   r_toff;
    logic                r_v0, r_v1, r_v2, r_v3;
    logic [PHASE_W-1:0]  r_el0, r_f0, r_po0, r_acc0;
    logic [PHASE_W-1:0]  r_po1, r_acc1;
    logic [PHASE_W-1:0]  r_sum2, r_acc2;
    logic [PHASE_W-1:0]  r_ph3;
    logic [2*LIMB_W-1:0] r_pp [NL][NL];

    assign w_adv   = ~r_v3 | m_ready;
    assign s_ready = w_adv & resetn;
    assign w_acc   = s_valid & s_ready;
    assign w_diff  = s_timestamp - r_toff;
    assign w_po    = {s_phase_ofs, {(PHASE_W-POFS_W){1'b0}}};
    assign m_valid = r_v3;
    assign m_phase = r_ph3;

    generate
        if (TIME_W >= PHASE_W) begin : g_trunc
            assign w_el = w_diff[PHASE_W-1:0];
        end else begin : g_zext
            assign w_el = {{(PHASE_W-TIME_W){1'b0}}, w_diff};
        end
    endgenerate

    // The offset load is independent of the pipeline stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_toff <= '0;
        end else if (cfg_load) begin
            r_toff <= cfg_time_offset;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v0   <= 1'b0;
            r_el0  <= '0;
            r_f0   <= '0;
            r_po0  <= '0;
            r_acc0 <= '0;
        end else if (w_adv) begin
            r_v0   <= s_valid;
            r_el0  <= w_el;
            r_f0   <= s_freq;
            r_po0  <= w_po;
            r_acc0 <= s_acc_phase;
        end
    end

    // Only limb pairs landing below PHASE_W are ever multiplied; the rest stay zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v1   <= 1'b0;
            r_po1  <= '0;
            r_acc1 <= '0;
            for (int i = 0; i < NL; i++)
                for (int j = 0; j < NL; j++)
                    r_pp[i][j] <= '0;
        end else if (w_adv) begin
            r_v1   <= r_v0;
            r_po1  <= r_po0;
            r_acc1 <= r_acc0;
            for (int i = 0; i < NL; i++)
                for (int j = 0; j < NL; j++)
                    r_pp[i][j] <= (i + j < NL)
                        ? {{LIMB_W{1'b0}}, r_el0[i*LIMB_W +: LIMB_W]} * {{LIMB_W{1'b0}}, r_f0[j*LIMB_W +: LIMB_W]}
                        : '0;
        end
    end

    always_comb begin
        w_sum = r_po1;
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < NL; j++)
                if (i + j < NL)
                    w_sum = w_sum + PHASE_W'({{PHASE_W{1'b0}}, r_pp[i][j]} << (LIMB_W * (i + j)));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v2   <= 1'b0;
            r_sum2 <= '0;
            r_acc2 <= '0;
            r_v3   <= 1'b0;
            r_ph3  <= '0;
        end else if (w_adv) begin
            r_v2   <= r_v1;
            r_sum2 <= w_sum;
            r_acc2 <= r_acc1;
            r_v3   <= r_v2;
            r_ph3  <= r_sum2 + r_acc2;
        end
    end

`ifdef DDS_PHASE_MAC_NEGTIME_EN
    logic        w_neg;
    logic        r_neg0, r_neg1, r_neg2, r_neg3;
    logic [15:0] r_err;

    assign w_neg = s_timestamp < r_toff;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_neg0 <= 1'b0;
            r_neg1 <= 1'b0;
            r_neg2 <= 1'b0;
            r_neg3 <= 1'b0;
            r_err  <= '0;
        end else begin
            if (w_adv) begin
                r_neg0 <= w_neg;
                r_neg1 <= r_neg0;
                r_neg2 <= r_neg1;
                r_neg3 <= r_neg2;
            end
            if (cfg_load)
                r_err <= {15'd0, w_acc & w_neg};
            else if (w_acc && w_neg && r_err != 16'hFFFF)
                r_err <= r_err + 16'd1;
        end
    end

    assign m_neg_time = r_neg3;
    assign err_cnt    = r_err;
`else
    assign m_neg_time = 1'b0;
    assign err_cnt    = '0;
`endif
endmodule

// File: tb/tb_dds_phase_mac_pipe.sv
// tb_dds_phase_mac_pipe: directed self-checking bench for dds_phase_mac_pipe.
`timescale 1ns/1ps
module tb_dds_phase_mac_pipe;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_load = 1'b0;
    logic [47:0] cfg_time_offset = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [47:0] s_timestamp = '0;
    logic [47:0] s_freq = '0;
    logic [13:0] s_phase_ofs = '0;
    logic [47:0] s_acc_phase = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [47:0] m_phase;
    logic        m_neg_time;
    logic [15:0] err_cnt;
    int n_tests = 0;
    int n_fail = 0;

`ifdef DDS_PHASE_MAC_NEGTIME_EN
    localparam logic NEG_EN = 1'b1;
`else
    localparam logic NEG_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    dds_phase_mac_pipe dut (
        .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_time_offset(cfg_time_offset),
        .s_valid(s_valid), .s_ready(s_ready), .s_timestamp(s_timestamp), .s_freq(s_freq),
        .s_phase_ofs(s_phase_ofs), .s_acc_phase(s_acc_phase), .m_valid(m_valid), .m_ready(m_ready),
        .m_phase(m_phase), .m_neg_time(m_neg_time), .err_cnt(err_cnt)
    );

    task automatic cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic load_toff(input logic [47:0] v);
        cfg_load = 1'b1;
        cfg_time_offset = v;
        cycle;
        cfg_load = 1'b0;
    endtask

    // Sends one sample into an idle pipe and waits (bounded) for its result.
    task automatic run1(input logic [47:0] ts, input logic [47:0] f, input logic [13:0] po,
                        input logic [47:0] acc, output logic [47:0] ph, output logic ng, output int lat);
        s_valid = 1'b1;
        s_timestamp = ts;
        s_freq = f;
        s_phase_ofs = po;
        s_acc_phase = acc;
        cycle;
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 12) begin
            cycle;
            lat++;
        end
        ph = m_phase;
        ng = m_neg_time;
        if (!m_valid) lat = -1;
    endtask

    task automatic test_reset;
        cycle;
        cycle;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_phase !== 48'h0) begin n_fail++; $display("FAIL reset_m_phase: got %h expected 0", m_phase); end
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        n_tests++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt: got %h expected 0", err_cnt); end
        n_tests++; if (m_neg_time !== 1'b0) begin n_fail++; $display("FAIL reset_neg: got %b expected 0", m_neg_time); end
        resetn = 1'b1;
        #1;
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready: got %b expected 1", s_ready); end
        cycle;
    endtask

    task automatic test_basic;
        load_toff(48'd100);
        s_valid = 1'b1;
        s_timestamp = 48'd110;
        s_freq = 48'h1_0000_0000;
        s_phase_ofs = '0;
        s_acc_phase = '0;
        cycle;
        s_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid_%0d: got %b expected 0", k, m_valid); end
            cycle;
        end
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b expected 1", m_valid); end
        n_tests++; if (m_phase !== 48'h000A_0000_0000) begin n_fail++; $display("FAIL basic_phase: got %h expected 000a00000000", m_phase); end
        n_tests++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL basic_err_cnt: got %h expected 0", err_cnt); end
        cycle;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_output: got %b expected 0", m_valid); end
    endtask

    task automatic test_wrap;
        logic [47:0] v_ts  [5] = '{48'd2, 48'd0, 48'h1_0001, 48'h1_0000_0000, 48'hFFFF_FFFF_FFFF};
        logic [47:0] v_f   [5] = '{48'hFFFF_FFFF_FFFF, 48'd0, 48'h0001_0001_0001, 48'h1_0000, 48'hFFFF_FFFF_FFFF};
        logic [13:0] v_po  [5] = '{14'd0, 14'h3FFF, 14'd1, 14'd0, 14'h3FFF};
        logic [47:0] v_acc [5] = '{48'h5, 48'd0, 48'h10, 48'h7, 48'hFFFF_FFFF_FFFF};
        logic [47:0] v_exp [5] = '{48'h3, 48'hFFFC_0000_0000, 48'h0006_0002_0011, 48'h7, 48'hFFFC_0000_0000};
        logic [47:0] ph;
        logic ng;
        int lat;
        load_toff(48'd0);
        for (int k = 0; k < 5; k++) begin
            run1(v_ts[k], v_f[k], v_po[k], v_acc[k], ph, ng, lat);
            n_tests++; if (ph !== v_exp[k]) begin n_fail++; $display("FAIL wrap_phase_%0d: got %h expected %h", k, ph, v_exp[k]); end
            n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL wrap_latency_%0d: got %0d expected 4", k, lat); end
        end
        cycle;
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int rcv = 0;
        int n_stall = 0;
        logic was_stall = 1'b0;
        logic [47:0] ph_hold = '0;
        load_toff(48'd0);
        s_freq = 48'd1;
        s_phase_ofs = '0;
        s_acc_phase = '0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            s_valid = (sent < 6);
            s_timestamp = 48'(sent + 1);
            m_ready = !(c >= 3 && c <= 5);
            #1;
            if (was_stall) begin
                n_tests++; if (m_valid !== 1'b1 || m_phase !== ph_hold) begin n_fail++; $display("FAIL bp_hold_c%0d: got v=%b %h expected v=1 %h", c, m_valid, m_phase, ph_hold); end
            end
            was_stall = m_valid && !m_ready;
            if (was_stall) begin
                n_stall++;
                ph_hold = m_phase;
                n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready_c%0d: got %b expected 0", c, s_ready); end
            end
            if (m_valid && m_ready) begin
                n_tests++; if (m_phase !== 48'(rcv + 1)) begin n_fail++; $display("FAIL bp_order_%0d: got %h expected %h", rcv, m_phase, 48'(rcv + 1)); end
                rcv++;
            end
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        n_tests++; if (rcv !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", rcv); end
        n_tests++; if (n_stall !== 2) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 2", n_stall); end
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_output_%0d: got %b expected 0", k, m_valid); end
            cycle;
        end
    endtask

    task automatic test_offset_timing;
        logic [47:0] got [2];
        int n = 0;
        s_freq = 48'd1;
        s_phase_ofs = '0;
        s_acc_phase = '0;
        cfg_load = 1'b1;
        cfg_time_offset = 48'd50;
        s_valid = 1'b1;
        s_timestamp = 48'd60;
        cycle;
        cfg_load = 1'b0;
        cycle;
        s_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (m_valid && n < 2) begin
                got[n] = m_phase;
                n++;
            end
            cycle;
        end
        n_tests++; if (n !== 2) begin n_fail++; $display("FAIL toff_count: got %0d expected 2", n); end
        n_tests++; if (got[0] !== 48'd60) begin n_fail++; $display("FAIL toff_old: got %h expected %h", got[0], 48'd60); end
        n_tests++; if (got[1] !== 48'd10) begin n_fail++; $display("FAIL toff_new: got %h expected %h", got[1], 48'd10); end
    endtask

    task automatic test_negtime;
        logic [47:0] ph;
        logic ng;
        int lat;
        load_toff(48'd10);
        run1(48'd5, 48'd1, 14'd0, 48'd0, ph, ng, lat);
        n_tests++; if (ph !== 48'hFFFF_FFFF_FFFB) begin n_fail++; $display("FAIL neg_phase: got %h expected fffffffffffb", ph); end
        n_tests++; if (ng !== NEG_EN) begin n_fail++; $display("FAIL neg_flag: got %b expected %b", ng, NEG_EN); end
        n_tests++; if (err_cnt !== {15'd0, NEG_EN}) begin n_fail++; $display("FAIL neg_err_cnt: got %h expected %h", err_cnt, {15'd0, NEG_EN}); end
        run1(48'd20, 48'd1, 14'd0, 48'd0, ph, ng, lat);
        n_tests++; if (ph !== 48'd10 || ng !== 1'b0) begin n_fail++; $display("FAIL pos_sample: got %h/%b expected 00000000000a/0", ph, ng); end
        n_tests++; if (err_cnt !== {15'd0, NEG_EN}) begin n_fail++; $display("FAIL pos_err_hold: got %h expected %h", err_cnt, {15'd0, NEG_EN}); end
        load_toff(48'd10);
        n_tests++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL err_clear: got %h expected 0", err_cnt); end
        cfg_load = 1'b1;
        s_valid = 1'b1;
        s_timestamp = 48'd5;
        cycle;
        cfg_load = 1'b0;
        s_valid = 1'b0;
        n_tests++; if (err_cnt !== {15'd0, NEG_EN}) begin n_fail++; $display("FAIL err_clear_coincide: got %h expected %h", err_cnt, {15'd0, NEG_EN}); end
        for (int k = 0; k < 6; k++) cycle;
    endtask

    task automatic test_reset_midstream;
        logic [47:0] ph;
        logic ng;
        int lat;
        load_toff(48'd77);
        s_freq = 48'd1;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_timestamp = 48'(100 + k);
            cycle;
        end
        s_valid = 1'b0;
        n_tests++; if (m_valid !== 1'b1 || m_phase !== 48'd23) begin n_fail++; $display("FAIL mid_pre_valid: got %b/%h expected 1/000000000017", m_valid, m_phase); end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_phase !== 48'h0) begin n_fail++; $display("FAIL mid_async_phase: got %h expected 0", m_phase); end
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async_s_ready: got %b expected 0", s_ready); end
        cycle;
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_%0d: got %b expected 0", k, m_valid); end
            cycle;
        end
        run1(48'd5, 48'd1, 14'd0, 48'd0, ph, ng, lat);
        n_tests++; if (ph !== 48'd5 || lat !== 4) begin n_fail++; $display("FAIL mid_toff_cleared: got %h lat %0d expected 000000000005 lat 4", ph, lat); end
        cycle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_back_to_back;
        test_offset_timing;
        test_negtime;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
